register: RTL and testbench

REGISTER -- requirements
Module: register

---
 rtl/register_pkg.sv | 23 ++
 rtl/register_vol_button.sv | 69 ++++++
 rtl/register.sv | 69 ++++++
 tb/tb_register.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared constants, types and the level-to-gain mapping for the volume register.
//   LEVEL_W/GAIN_W  : widths of the volume level and of the audio gain code
//   LEVEL_MIN/MAX   : saturation bounds of the volume level
//   DEF_*           : default values for the top-level parameters
package register_pkg;

  localparam int unsigned LEVEL_W           = 4;
  localparam int unsigned GAIN_W            = 8;
  localparam int unsigned LEVEL_MIN         = 0;
  localparam int unsigned LEVEL_MAX         = 15;
  localparam int unsigned DEF_RESET_LEVEL   = 8;
  localparam int unsigned DEF_REPEAT_DELAY  = 8;
  localparam int unsigned DEF_REPEAT_PERIOD = 4;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [GAIN_W-1:0]  gain_t;

  // Gain code is the level replicated into both nibbles, i.e. level * 17.
  function automatic gain_t gain_of(input level_t level);
    return {level, level};
  endfunction

endpackage

// File: rtl/register_vol_button.sv
// One volume button: 2-flop synchronizer, rising-edge detect and hold/repeat
// counter. Emits a one-cycle step pulse on the press and, while held, again
// after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   btn    : asynchronous button level
//   step_c : combinational one-cycle step request
module register_vol_button
  import register_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step_c
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic             meta;
  logic             sync;
  logic             hist;
  logic [CNT_W-1:0] cnt;
  logic             rep;
  logic             rise_c;
  logic             fire_c;

  // cnt holds cycles since the last step; rep selects the delay or period target.
  always_comb begin
    rise_c = sync & ~hist;
    fire_c = 1'b0;
    if (sync && hist) begin
      if (rep) fire_c = (cnt == CNT_W'(REPEAT_PERIOD));
      else     fire_c = (cnt == CNT_W'(REPEAT_DELAY));
    end
    step_c = rise_c | fire_c;
  end

  // Synchronizer, edge history and hold counter; a low level clears the counter at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
      cnt  <= '0;
      rep  <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      hist <= sync;
      if (!sync) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (rise_c) begin
        cnt <= CNT_W'(1);
        rep <= 1'b0;
      end else if (fire_c) begin
        cnt <= CNT_W'(1);
        rep <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/register.sv
// Volume register: holds a saturating 4-bit level driven by up/down buttons
// with auto-repeat, and presents it as a hex digit and an 8-bit gain code.
//   Clk      : system clock
//   Reset    : synchronous active-low reset (loads RESET_LEVEL)
//   Vol_up   : asynchronous raise request (button level)
//   Vol_down : asynchronous lower request (button level)
//   Data     : registered gain code, level * 17
//   hex_vol  : registered current level 0..15
module register
  import register_pkg::*;
#(
  parameter int unsigned RESET_LEVEL   = DEF_RESET_LEVEL,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Vol_up,
  input  logic              Vol_down,
  output logic [GAIN_W-1:0] Data,
  output logic [LEVEL_W-1:0] hex_vol
);

  logic   up_step_c;
  logic   down_step_c;
  level_t level_nxt_c;

  register_vol_button #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_up (
    .clk   (Clk),
    .rst_n (Reset),
    .btn   (Vol_up),
    .step_c(up_step_c)
  );

  register_vol_button #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_down (
    .clk   (Clk),
    .rst_n (Reset),
    .btn   (Vol_down),
    .step_c(down_step_c)
  );

  // Saturating step; simultaneous up and down requests cancel.
  always_comb begin
    level_nxt_c = hex_vol;
    if (up_step_c && !down_step_c && (hex_vol != LEVEL_W'(LEVEL_MAX))) begin
      level_nxt_c = hex_vol + LEVEL_W'(1);
    end else if (down_step_c && !up_step_c && (hex_vol != LEVEL_W'(LEVEL_MIN))) begin
      level_nxt_c = hex_vol - LEVEL_W'(1);
    end
  end

  // Level and gain code share one edge so the two outputs never disagree.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hex_vol <= LEVEL_W'(RESET_LEVEL);
      Data    <= gain_of(LEVEL_W'(RESET_LEVEL));
    end else begin
      hex_vol <= level_nxt_c;
      Data    <= gain_of(level_nxt_c);
    end
  end

endmodule

// File: tb/tb_register.sv
// Bench for the volume register: directed scenarios with literal expectations
// followed by randomized button/reset traffic checked every cycle against a
// run-length behavioural model.
module tb_register;

  localparam int RL     = 8;
  localparam int DELAY  = 8;
  localparam int PERIOD = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Vol_up = 1'b0;
  logic       Vol_down = 1'b0;
  logic [7:0] Data;
  logic [3:0] hex_vol;

  int n_chk  = 0;
  int n_fail = 0;

  register #(
    .RESET_LEVEL  (RL),
    .REPEAT_DELAY (DELAY),
    .REPEAT_PERIOD(PERIOD)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Vol_up  (Vol_up),
    .Vol_down(Vol_down),
    .Data    (Data),
    .hex_vol (hex_vol)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: a button held for r consecutive synchronized samples
  // steps when r==1 (press), r-1==DELAY, and every PERIOD samples after that.
  int  model_l = RL;
  bit  model_valid = 1'b0;
  int  run_up = 0, run_dn = 0;
  bit  up_d1 = 0, up_d2 = 0, dn_d1 = 0, dn_d2 = 0;

  function automatic bit fires(input int r);
    if (r <= 0) return 1'b0;
    if (r == 1) return 1'b1;
    if (r - 1 < DELAY) return 1'b0;
    return ((r - 1 - DELAY) % PERIOD) == 0;
  endfunction

  always @(posedge Clk) begin
    bit su, sd;
    if (!Reset) begin
      model_l = RL;
      run_up = 0; run_dn = 0;
      up_d1 = 0; up_d2 = 0; dn_d1 = 0; dn_d2 = 0;
      model_valid = 1'b1;
    end else begin
      run_up = up_d2 ? run_up + 1 : 0;
      run_dn = dn_d2 ? run_dn + 1 : 0;
      su = fires(run_up);
      sd = fires(run_dn);
      if (su && !sd && model_l < 15) model_l = model_l + 1;
      else if (sd && !su && model_l > 0) model_l = model_l - 1;
      up_d2 = up_d1; up_d1 = Vol_up;
      dn_d2 = dn_d1; dn_d1 = Vol_down;
    end
  end

  // Per-cycle comparison of both outputs against the model.
  always @(posedge Clk) begin
    #1;
    if (model_valid) begin
      chk("hex_vol_vs_model", int'(hex_vol), model_l);
      chk("data_vs_model", int'(Data), model_l * 17);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Vol_up = 0; Vol_down = 0; Reset = 0;
    tick(2);
    Reset = 1;
    tick(3);
  endtask

  initial begin
    // Reset two cycles, inputs low.
    do_reset();
    tick(2);
    chk("reset_hex", int'(hex_vol), 8);
    chk("reset_data", int'(Data), 8'h88);
    chk("reset_model", model_l, 8);

    // Single one-cycle press: one step, landing two edges after the first sample.
    Vol_up = 1;
    tick(1);
    Vol_up = 0;
    chk("pulse_edge_k", int'(hex_vol), 8);
    tick(1);
    chk("pulse_edge_k1", int'(hex_vol), 8);
    tick(1);
    chk("pulse_edge_k2_hex", int'(hex_vol), 9);
    chk("pulse_edge_k2_data", int'(Data), 8'h99);
    tick(6);
    chk("pulse_single_step", int'(hex_vol), 9);
    chk("pulse_model", model_l, 9);

    // Hold up 40 cycles from 8: steps after edges 3, 11, 15, ... saturating at 15.
    do_reset();
    Vol_up = 1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (i == 2)  chk("hold_i2", int'(hex_vol), 8);
      if (i == 3)  chk("hold_i3", int'(hex_vol), 9);
      if (i == 10) chk("hold_i10", int'(hex_vol), 9);
      if (i == 11) chk("hold_i11", int'(hex_vol), 10);
      if (i == 15) chk("hold_i15", int'(hex_vol), 11);
      if (i == 30) chk("hold_i30", int'(hex_vol), 14);
      if (i == 31) chk("hold_i31_data", int'(Data), 8'hFF);
      if (i == 40) chk("hold_i40_sat", int'(hex_vol), 15);
    end
    Vol_up = 0;
    tick(4);

    // From 15, down held 3 cycles: one step only.
    Vol_down = 1;
    tick(3);
    Vol_down = 0;
    tick(5);
    chk("down3_from15", int'(hex_vol), 14);

    // Drive to 0 then pulse down: stays at 0.
    do_reset();
    Vol_down = 1;
    tick(45);
    Vol_down = 0;
    tick(4);
    chk("down_to_zero", int'(hex_vol), 0);
    Vol_down = 1;
    tick(1);
    Vol_down = 0;
    tick(5);
    chk("down_sat_zero", int'(hex_vol), 0);
    chk("down_sat_zero_data", int'(Data), 0);

    // Reach 5 (steps at edges 3, 11, 15), then simultaneous press cancels.
    do_reset();
    Vol_down = 1;
    tick(13);
    Vol_down = 0;
    tick(6);
    chk("reach5", int'(hex_vol), 5);
    Vol_up = 1; Vol_down = 1;
    tick(1);
    Vol_up = 0; Vol_down = 0;
    tick(5);
    chk("cancel_hex", int'(hex_vol), 5);
    chk("cancel_data", int'(Data), 8'h55);

    // Reset mid auto-repeat at 12 with up still held, then a fresh press.
    do_reset();
    Vol_up = 1;
    tick(21);
    chk("repeat_at12", int'(hex_vol), 12);
    Reset = 0;
    tick(1);
    chk("mid_repeat_reset", int'(hex_vol), 8);
    Reset = 1;
    tick(1);
    chk("after_release_e1", int'(hex_vol), 8);
    tick(1);
    chk("after_release_e2", int'(hex_vol), 8);
    tick(1);
    chk("after_release_new_press", int'(hex_vol), 9);
    Vol_up = 0;
    tick(4);
    chk("after_release_single", int'(hex_vol), 9);

    // Randomized traffic: sticky button levels with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 11) == 0) Vol_up = ~Vol_up;
      if ($urandom_range(0, 11) == 0) Vol_down = ~Vol_down;
    end
    Reset = 1; Vol_up = 0; Vol_down = 0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
